// File: rtl/add_rr_arbiter.sv
// Round-robin arbiter that time-shares one external ripple-carry adder among
// four requesters and returns each sum on a valid/ready response port.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for a request; arbitrates and loads the adder inputs
// ST_ADD  | grant pulse high, adder settling; sum captured at the edge
// ST_HOLD | response presented until rsp_ready is sampled high
module add_rr_arbiter #(
  parameter int N = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*N-1:0] a_in,
  input  logic [4*N-1:0] b_in,
  input  logic [3:0]     cin_in,
  output logic [3:0]     gnt,
  output logic [N-1:0]   add_a,
  output logic [N-1:0]   add_b,
  output logic           add_cin,
  input  logic [N-1:0]   add_sum,
  input  logic           add_carry,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [1:0]     rsp_id,
  output logic [N-1:0]   rsp_sum,
  output logic           rsp_carry,
  output logic           busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [3:0]     gnt_q, gnt_d;
  logic [N-1:0]   add_a_q, add_a_d;
  logic [N-1:0]   add_b_q, add_b_d;
  logic           add_cin_q, add_cin_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [1:0]     rsp_id_q, rsp_id_d;
  logic [N-1:0]   rsp_sum_q, rsp_sum_d;
  logic           rsp_carry_q, rsp_carry_d;

  logic           win_found;
  logic [1:0]     win_idx;
  logic [1:0]     cand;

  // Search starts just after the last winner, so the last winner is lowest.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          add_a_d   = a_in[32'(win_idx)*N +: N];
          add_b_d   = b_in[32'(win_idx)*N +: N];
          add_cin_d = cin_in[win_idx];
          gnt_d     = 4'b0001 << win_idx;
          rsp_id_d  = win_idx;
          ptr_d     = win_idx;
          state_d   = ST_ADD;
        end
      end
      ST_ADD: begin
        rsp_sum_d   = add_sum;
        rsp_carry_d = add_carry;
        rsp_valid_d = 1'b1;
        gnt_d       = 4'b0000;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        gnt_d       = 4'b0000;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 2'd3;
      gnt_q       <= 4'b0000;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 2'd0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  assign gnt       = gnt_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_add_rr_arbiter.sv
// Scoreboard bench for add_rr_arbiter: stimulus pushes expected grants and
// results from a round-robin reference model; a monitor pops and compares.
module tb_add_rr_arbiter;
  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic [4*N-1:0] a_in, b_in;
  logic [3:0]     cin_in;
  logic [3:0]     gnt;
  logic [N-1:0]   add_a, add_b, add_sum;
  logic           add_cin, add_carry;
  logic           rsp_valid, rsp_ready, rsp_carry, busy;
  logic [1:0]     rsp_id;
  logic [N-1:0]   rsp_sum;

  typedef struct {
    int           id;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
  } gexp_t;

  typedef struct {
    int         id;
    logic [N:0] res;
  } rexp_t;

  gexp_t exp_g[$];
  rexp_t exp_r[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ptr_m = 3;
  logic rdy_force = 1'b1;
  logic rdy_val = 1'b1;

  add_rr_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_carry(add_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .busy(busy)
  );

  // External shared adder.
  assign {add_carry, add_sum} = (N+1)'(add_a) + (N+1)'(add_b) + (N+1)'(add_cin);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = rdy_force ? rdy_val : 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arbitration: first asserted request after the last winner, modulo 4.
  function automatic int pick(input int p, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic set_op(input int i, input int a, input int b, input int c);
    a_in[i*N +: N] = N'(a);
    b_in[i*N +: N] = N'(b);
    cin_in[i]      = 1'(c);
  endtask

  task automatic set_rand(input int i);
    set_op(i, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1));
  endtask

  task automatic arb_step(output int w, output int waited);
    gexp_t g;
    rexp_t r;
    w = pick(ptr_m, req);
    if (w >= 0) begin
      ptr_m = w;
      g.id  = w;
      g.a   = a_in[w*N +: N];
      g.b   = b_in[w*N +: N];
      g.cin = cin_in[w];
      r.id  = w;
      r.res = (N+1)'(int'(g.a) + int'(g.b) + int'(g.cin));
      exp_g.push_back(g);
      exp_r.push_back(r);
    end
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (gnt == 4'b0 && waited < 200);
    if (gnt == 4'b0) chk("grant_timeout", 32'(gnt), 32'(4'b0001 << w));
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || rsp_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy | rsp_valid), 0);
  endtask

  task automatic chk_reset();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_add_a", 32'(add_a), 0);
    chk("rst_add_b", 32'(add_b), 0);
    chk("rst_add_cin", 32'(add_cin), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_sum", 32'(rsp_sum), 0);
    chk("rst_rsp_carry", 32'(rsp_carry), 0);
    chk("rst_busy", 32'(busy), 0);
  endtask

  // Monitor: grant and response checks against the scoreboard queues.
  int           last_gnt = -1;
  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic [1:0]   hold_id;
  logic [N:0]   hold_res;

  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    if (rst) begin
      last_gnt   = -1;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (gnt != 4'b0) begin
        if (exp_g.size() == 0) begin
          chk("unexpected_gnt", 32'(gnt), 0);
        end else begin
          g = exp_g.pop_front();
          chk("gnt_onehot", 32'(gnt), 32'(4'b0001 << g.id));
          chk("gnt_add_a", 32'(add_a), 32'(g.a));
          chk("gnt_add_b", 32'(add_b), 32'(g.b));
          chk("gnt_add_cin", 32'(add_cin), 32'(g.cin));
          chk("gnt_while_valid", 32'(rsp_valid), 0);
          chk("gnt_busy", 32'(busy), 1);
          if (last_gnt >= 0) chk("gnt_spacing_ge3", 32'(cyc - last_gnt >= 3), 1);
          last_gnt = cyc;
        end
      end
      if (rsp_valid && !prev_valid) begin
        if (exp_r.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 0);
        end else begin
          r = exp_r.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(r.id));
          chk("rsp_result", 32'({rsp_carry, rsp_sum}), 32'(r.res));
        end
        hold_id  = rsp_id;
        hold_res = {rsp_carry, rsp_sum};
      end else if (prev_valid && !prev_ready) begin
        chk("rsp_hold_valid", 32'(rsp_valid), 1);
        chk("rsp_hold_id", 32'(rsp_id), 32'(hold_id));
        chk("rsp_hold_result", 32'({rsp_carry, rsp_sum}), 32'(hold_res));
      end else if (prev_valid && prev_ready) begin
        chk("rsp_release", 32'(rsp_valid), 0);
      end
      prev_valid = rsp_valid;
      prev_ready = rsp_ready;
    end
  end

  initial begin
    int w, wt;
    rst    = 1'b1;
    req    = 4'b0;
    a_in   = '0;
    b_in   = '0;
    cin_in = 4'b0;
    repeat (3) @(negedge clk);
    chk_reset();
    #1 rst = 1'b0;

    // Fairness with all four requesting and the consumer always ready.
    for (int i = 0; i < 4; i++) set_rand(i);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      arb_step(w, wt);
      if (n > 0) chk("rr_period", 32'(wt), 3);
      set_rand(w);
    end
    req = 4'b0;

    // Single request from the worked example: 10100 + 10010 + 0.
    wait_idle();
    set_op(0, 5'b10100, 5'b10010, 0);
    req = 4'b0001;
    arb_step(w, wt);
    chk("single_latency", 32'(wt), 1);
    chk("single_add_a", 32'(add_a), 32'(5'b10100));
    req = 4'b0;
    @(negedge clk);
    chk("single_gnt_cleared", 32'(gnt), 0);
    chk("single_rsp_valid", 32'(rsp_valid), 1);
    chk("single_rsp_sum", 32'(rsp_sum), 32'(5'b00110));
    chk("single_rsp_carry", 32'(rsp_carry), 1);

    // Overflow boundaries.
    set_op(1, 31, 31, 1);
    req = 4'b0010;
    arb_step(w, wt);
    req = 4'b0;
    @(negedge clk);
    chk("ovf_max_sum", 32'(rsp_sum), 32'(5'b11111));
    chk("ovf_max_carry", 32'(rsp_carry), 1);
    set_op(2, 0, 0, 0);
    req = 4'b0100;
    arb_step(w, wt);
    req = 4'b0;
    @(negedge clk);
    chk("ovf_zero_sum", 32'(rsp_sum), 0);
    chk("ovf_zero_carry", 32'(rsp_carry), 0);

    // Pointer wrap: 3, then 0 out of 1001, then 3 out of 1001.
    set_rand(3);
    req = 4'b1000;
    arb_step(w, wt);
    set_rand(3);
    set_rand(0);
    req = 4'b1001;
    arb_step(w, wt);
    set_rand(0);
    arb_step(w, wt);
    req = 4'b0;

    // Backpressure with requester 1 pending behind a held response.
    wait_idle();
    rdy_val = 1'b0;
    repeat (2) @(negedge clk);
    set_op(1, 7, 9, 1);
    req = 4'b0010;
    arb_step(w, wt);
    set_op(1, 12, 3, 0);
    @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_valid_held", 32'(rsp_valid), 1);
      chk("bp_sum_held", 32'(rsp_sum), 32'(5'd17));
      chk("bp_no_gnt", 32'(gnt), 0);
    end
    rdy_val = 1'b1;
    @(negedge clk);
    chk("bp_valid_before_edge", 32'(rsp_valid), 1);
    @(negedge clk);
    chk("bp_valid_fall", 32'(rsp_valid), 0);
    chk("bp_gnt_not_yet", 32'(gnt), 0);
    arb_step(w, wt);
    chk("bp_regrant_latency", 32'(wt), 1);
    chk("bp_regrant", 32'(gnt), 32'(4'b0010));
    req = 4'b0;

    // Reset asserted in the ADD cycle discards the transaction.
    wait_idle();
    set_op(0, 21, 6, 1);
    req = 4'b0001;
    arb_step(w, wt);
    #1;
    rst = 1'b1;
    req = 4'b0;
    void'(exp_r.pop_back());
    ptr_m = 3;
    @(negedge clk);
    chk_reset();
    #1;
    rst = 1'b0;
    set_op(2, 13, 17, 1);
    req = 4'b0100;
    arb_step(w, wt);
    chk("post_rst_latency", 32'(wt), 1);
    chk("post_rst_gnt", 32'(gnt), 32'(4'b0100));
    req = 4'b0;

    // Randomized traffic with random backpressure.
    rdy_force = 1'b0;
    for (int it = 0; it < 80; it++) begin
      for (int i = 0; i < 4; i++)
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          set_rand(i);
          req[i] = 1'b1;
        end
      if (req == 4'b0) begin
        int i = $urandom_range(0, 3);
        set_rand(i);
        req[i] = 1'b1;
      end
      arb_step(w, wt);
      if (w >= 0) begin
        if ($urandom_range(0, 2) == 0) set_rand(w);
        else req[w] = 1'b0;
      end
    end
    req = 4'b0;

    rdy_force = 1'b1;
    rdy_val   = 1'b1;
    wait_idle();
    chk("gnt_queue_drained", 32'(exp_g.size()), 0);
    chk("rsp_queue_drained", 32'(exp_r.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
